// File: rtl/perip_bridge_pkg.sv
// perip_bridge_pkg: shared FSM state type, address-index field and default error data for the peripheral bridge
package perip_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} pb_state_e;
  localparam int PB_IDX_MSB = 31;
  localparam int PB_IDX_LSB = 28;
  localparam logic [31:0] PB_ERR_RDATA = 32'h0000_0000;
endpackage

// File: rtl/perip_addr_decode.sv
// perip_addr_decode: maps addr[31:28] to a one-hot slave select, flagging indices beyond NSLV as unmapped
module perip_addr_decode
  import perip_bridge_pkg::*;
#(
  parameter int NSLV = 4
) (
  input  logic [31:0]     addr_i,
  output logic [NSLV-1:0] sel_o,
  output logic            unmapped_o
);
  localparam logic [4:0] NSLV_W = 5'(NSLV);
  logic [3:0] idx;
  assign idx        = addr_i[PB_IDX_MSB:PB_IDX_LSB];
  assign unmapped_o = {1'b0, idx} >= NSLV_W;
  assign sel_o      = unmapped_o ? '0 : NSLV'(1) << idx;
endmodule

// File: rtl/perip_bridge.sv
// perip_bridge: stalls the core while one load/store is carried to a decoded peripheral slave over valid/ready.
// Optional PERIP_BRIDGE_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without ready.
module perip_bridge
  import perip_bridge_pkg::*;
#(
  parameter int          NSLV           = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = PB_ERR_RDATA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 perip_req_i,
  input  logic                 perip_wr_en_i,
  input  logic [31:0]          perip_addr_i,
  input  logic [31:0]          perip_wdata_i,
  output logic [31:0]          perip_rdata_o,
  output logic                 rib_hold_flag_o,
  output logic [NSLV-1:0]      s_sel_o,
  output logic                 s_valid_o,
  output logic                 s_we_o,
  output logic [31:0]          s_addr_o,
  output logic [31:0]          s_wdata_o,
  input  logic [NSLV-1:0]      s_ready_i,
  input  logic [NSLV*32-1:0]   s_rdata_i,
  output logic                 err_o
);
  pb_state_e       state_q, state_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
  logic            we_q, we_d, valid_q, valid_d, err_q, err_d, sel_rdy, unmapped, expired;
  logic [NSLV-1:0] sel_q, sel_d, dec_sel;

  perip_addr_decode #(.NSLV(NSLV)) u_dec (
    .addr_i     (perip_addr_i),
    .sel_o      (dec_sel),
    .unmapped_o (unmapped)
  );

  assign sel_rdy = |(s_ready_i & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) sel_rdata = sel_rdata | (sel_q[k] ? s_rdata_i[32*k +: 32] : 32'h0);
  end

`ifdef PERIP_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // Cleared on every IDLE cycle so each access starts counting from zero.
  assign cnt_d = state_q == IDLE ? '0 : (state_q == ACCESS && !sel_rdy) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (perip_req_i) begin
        if (unmapped) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = perip_addr_i;
          wdata_d = perip_wdata_i;
          we_d    = perip_wr_en_i;
          sel_d   = dec_sel;
          valid_d = 1'b1;
          state_d = ACCESS;
        end
      end
      // Ready in the expiry cycle takes priority over the timeout abort.
      ACCESS: if (sel_rdy || expired) begin
        rdata_d = we_q ? rdata_q : sel_rdy ? sel_rdata : ERR_RDATA;
        err_d   = !sel_rdy;
        valid_d = 1'b0;
        sel_d   = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rib_hold_flag_o = state_q == IDLE ? perip_req_i : state_q == ACCESS;
  assign perip_rdata_o   = rdata_q;
  assign s_sel_o         = sel_q;
  assign s_valid_o       = valid_q;
  assign s_we_o          = we_q;
  assign s_addr_o        = addr_q;
  assign s_wdata_o       = wdata_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: directed-vector bench for perip_bridge; timeout scenario depends on PERIP_BRIDGE_TIMEOUT_EN
module tb_perip_bridge;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         perip_req_i = 1'b0, perip_wr_en_i = 1'b0;
  logic [31:0]  perip_addr_i = '0, perip_wdata_i = '0;
  logic [31:0]  perip_rdata_o, s_addr_o, s_wdata_o;
  logic         rib_hold_flag_o, s_valid_o, s_we_o, err_o;
  logic [3:0]   s_sel_o, s_ready_i = '0;
  logic [127:0] s_rdata_i = '0;
  int n_cmp = 0, n_err = 0;

  perip_bridge #(.NSLV(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .perip_req_i(perip_req_i), .perip_wr_en_i(perip_wr_en_i),
    .perip_addr_i(perip_addr_i), .perip_wdata_i(perip_wdata_i), .perip_rdata_o(perip_rdata_o),
    .rib_hold_flag_o(rib_hold_flag_o), .s_sel_o(s_sel_o), .s_valid_o(s_valid_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (perip_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", perip_rdata_o); end
    n_cmp++; if (rib_hold_flag_o !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b want 0", rib_hold_flag_o); end
    n_cmp++; if ({s_sel_o, s_valid_o, s_we_o, err_o} !== 7'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0", {s_sel_o, s_valid_o, s_we_o, err_o}); end
    n_cmp++; if ({s_addr_o, s_wdata_o} !== 64'h0) begin n_err++; $display("FAIL rst_bus: got %h want 0", {s_addr_o, s_wdata_o}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    s_rdata_i = {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111};
    s_ready_i = 4'b0010;
    perip_addr_i = 32'h1000_0004; perip_wr_en_i = 1'b0; perip_req_i = 1'b1; #1;
    n_cmp++; if (rib_hold_flag_o !== 1'b1) begin n_err++; $display("FAIL zw_hold_T: got %b want 1", rib_hold_flag_o); end
    @(negedge clk);
    n_cmp++; if ({rib_hold_flag_o, s_valid_o, s_sel_o} !== 6'b11_0010) begin n_err++; $display("FAIL zw_access: got %b want 110010", {rib_hold_flag_o, s_valid_o, s_sel_o}); end
    n_cmp++; if (s_addr_o !== 32'h1000_0004) begin n_err++; $display("FAIL zw_addr: got %h want 10000004", s_addr_o); end
    @(negedge clk);
    n_cmp++; if (perip_rdata_o !== 32'hCAFE_F00D) begin n_err++; $display("FAIL zw_rdata: got %h want cafef00d", perip_rdata_o); end
    n_cmp++; if ({rib_hold_flag_o, s_valid_o, s_sel_o, err_o} !== 7'b0) begin n_err++; $display("FAIL zw_done: got %b want 0", {rib_hold_flag_o, s_valid_o, s_sel_o, err_o}); end
    perip_req_i = 1'b0; s_ready_i = '0;
  endtask

  task automatic test_store_wait();
    int holds;
    @(negedge clk);
    s_rdata_i[95:64] = 32'hDEAD_BEEF;
    perip_addr_i = 32'h2000_0010; perip_wdata_i = 32'h1234_5678; perip_wr_en_i = 1'b1; perip_req_i = 1'b1; #1;
    holds = rib_hold_flag_o ? 1 : 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      holds += rib_hold_flag_o ? 1 : 0;
      n_cmp++; if ({s_valid_o, s_we_o, s_sel_o} !== 6'b11_0100) begin n_err++; $display("FAIL st_ctrl%0d: got %b want 110100", i, {s_valid_o, s_we_o, s_sel_o}); end
      if (i == 4) s_ready_i = 4'b0100;
    end
    n_cmp++; if (s_wdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL st_wdata: got %h want 12345678", s_wdata_o); end
    @(negedge clk);
    holds += rib_hold_flag_o ? 1 : 0;
    n_cmp++; if (holds !== 5) begin n_err++; $display("FAIL st_holds: got %0d want 5", holds); end
    n_cmp++; if (perip_rdata_o !== 32'hCAFE_F00D) begin n_err++; $display("FAIL st_rdata: got %h want cafef00d", perip_rdata_o); end
    n_cmp++; if ({s_valid_o, s_sel_o, err_o} !== 6'b0) begin n_err++; $display("FAIL st_done: got %b want 0", {s_valid_o, s_sel_o, err_o}); end
    perip_req_i = 1'b0; perip_wr_en_i = 1'b0; s_ready_i = '0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    perip_addr_i = 32'h3000_0000; perip_wr_en_i = 1'b0; perip_req_i = 1'b1;
`ifdef PERIP_BRIDGE_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++; if ({s_valid_o, err_o, rib_hold_flag_o} !== 3'b101) begin n_err++; $display("FAIL to_wait%0d: got %b want 101", i, {s_valid_o, err_o, rib_hold_flag_o}); end
    end
    @(negedge clk);
    n_cmp++; if ({s_valid_o, s_sel_o, err_o, rib_hold_flag_o} !== 7'b0_0000_10) begin n_err++; $display("FAIL to_abort: got %b want 0000010", {s_valid_o, s_sel_o, err_o, rib_hold_flag_o}); end
    n_cmp++; if (perip_rdata_o !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 0", perip_rdata_o); end
    perip_req_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got %b want 0", err_o); end
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++; if ({s_valid_o, err_o, rib_hold_flag_o} !== 3'b101) begin n_err++; $display("FAIL nto_wait%0d: got %b want 101", i, {s_valid_o, err_o, rib_hold_flag_o}); end
    end
    s_ready_i = 4'b1000;
    @(negedge clk);
    n_cmp++; if ({perip_rdata_o, err_o, rib_hold_flag_o} !== {32'h4444_4444, 2'b00}) begin n_err++; $display("FAIL nto_done: got %h want 444444440", {perip_rdata_o, err_o, rib_hold_flag_o}); end
    perip_req_i = 1'b0; s_ready_i = '0;
    @(negedge clk);
`endif
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    perip_addr_i = 32'hF000_0000; perip_wr_en_i = 1'b0; perip_req_i = 1'b1; #1;
    n_cmp++; if ({rib_hold_flag_o, s_valid_o} !== 2'b10) begin n_err++; $display("FAIL um_T: got %b want 10", {rib_hold_flag_o, s_valid_o}); end
    @(negedge clk);
    n_cmp++; if ({err_o, rib_hold_flag_o, s_valid_o, s_sel_o} !== 7'b100_0000) begin n_err++; $display("FAIL um_done: got %b want 1000000", {err_o, rib_hold_flag_o, s_valid_o, s_sel_o}); end
    n_cmp++; if (perip_rdata_o !== 32'h0) begin n_err++; $display("FAIL um_rdata: got %h want 0", perip_rdata_o); end
    n_cmp++; if (s_addr_o !== 32'h3000_0000) begin n_err++; $display("FAIL um_addr_kept: got %h want 30000000", s_addr_o); end
    perip_req_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL um_err_pulse: got %b want 0", err_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    perip_addr_i = 32'h1000_0000; perip_wr_en_i = 1'b1; perip_wdata_i = 32'hAAAA_0000; perip_req_i = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (s_valid_o !== 1'b1) begin n_err++; $display("FAIL rm_pre: got %b want 1", s_valid_o); end
    rst_n = 1'b0; perip_req_i = 1'b0; #1;
    n_cmp++; if ({s_valid_o, s_sel_o, s_we_o, err_o, rib_hold_flag_o} !== 8'b0) begin n_err++; $display("FAIL rm_ctrl: got %b want 0", {s_valid_o, s_sel_o, s_we_o, err_o, rib_hold_flag_o}); end
    n_cmp++; if ({s_addr_o, s_wdata_o} !== 64'h0) begin n_err++; $display("FAIL rm_bus: got %h want 0", {s_addr_o, s_wdata_o}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    s_rdata_i[63:32] = 32'h5555_AAAA; s_ready_i = 4'b0010;
    perip_addr_i = 32'h1000_0008; perip_wr_en_i = 1'b0; perip_req_i = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({perip_rdata_o, rib_hold_flag_o} !== {32'h5555_AAAA, 1'b0}) begin n_err++; $display("FAIL rm_fresh: got %h want 5555aaaa0", {perip_rdata_o, rib_hold_flag_o}); end
    perip_req_i = 1'b0; s_ready_i = '0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    s_rdata_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    s_ready_i = 4'b1111;
    perip_addr_i = 32'h0000_0000; perip_wr_en_i = 1'b0; perip_req_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_sel_o !== 4'b0001) begin n_err++; $display("FAIL bb_sel_a: got %b want 0001", s_sel_o); end
    @(negedge clk);
    perip_addr_i = 32'h1000_0000; #1;
    n_cmp++; if ({perip_rdata_o, rib_hold_flag_o} !== {32'h1111_1111, 1'b0}) begin n_err++; $display("FAIL bb_done_a: got %h want 111111110", {perip_rdata_o, rib_hold_flag_o}); end
    @(negedge clk);
    n_cmp++; if ({rib_hold_flag_o, s_valid_o} !== 2'b10) begin n_err++; $display("FAIL bb_idle: got %b want 10", {rib_hold_flag_o, s_valid_o}); end
    @(negedge clk);
    n_cmp++; if ({s_valid_o, s_sel_o} !== 5'b1_0010) begin n_err++; $display("FAIL bb_sel_b: got %b want 10010", {s_valid_o, s_sel_o}); end
    @(negedge clk);
    n_cmp++; if ({perip_rdata_o, rib_hold_flag_o} !== {32'h2222_2222, 1'b0}) begin n_err++; $display("FAIL bb_done_b: got %h want 222222220", {perip_rdata_o, rib_hold_flag_o}); end
    perip_req_i = 1'b0; s_ready_i = '0;
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_timeout();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/perip_bridge.md
# perip_bridge

Peripheral bridge between the core's single-cycle data-memory port and variable-latency peripheral slaves.
- Latches each core load/store request and decodes the address to one of `NSLV` slaves.
- Runs a valid/ready handshake with the selected slave.
- Stalls the core pipeline via `rib_hold_flag_o` until the slave responds, times out, or the address is unmapped.

## Interface
Parameters:
- `NSLV`, 4: number of slaves; slave index = `addr[31:28]`, legal range 0..NSLV-1 (NSLV ≤ 16).
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles without `s_ready`, 1..65535.
- `ERR_RDATA`, 32'h0000_0000: read data returned on unmapped access or timeout.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `perip_req_i` in 1: core data request.
- `perip_wr_en_i` in 1: 1 = store, 0 = load.
- `perip_addr_i` in 32: byte address.
- `perip_wdata_i` in 32: store data.
- `perip_rdata_o` out 32: load data returned to the core.
- `rib_hold_flag_o` out 1: pipeline stall to the core.
- `s_sel_o` out NSLV: one-hot slave select.
- `s_valid_o` out 1: request valid to the slaves.
- `s_we_o` out 1: write enable to the slaves.
- `s_addr_o` out 32: latched address.
- `s_wdata_o` out 32: latched write data.
- `s_ready_i` in NSLV: per-slave ready.
- `s_rdata_i` in NSLV*32: per-slave read data; slave k occupies bits [32k+31:32k].
- `err_o` out 1: one-cycle pulse on unmapped access or timeout.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE, `perip_req_i`=1, address mapped:**
  - Latch addr, wdata and we into `s_addr_o`, `s_wdata_o`, `s_we_o`.
  - Set `s_sel_o` = one-hot(`addr[31:28]`) and `s_valid_o`=1.
  - Clear the timeout counter; go to ACCESS.
- **IDLE, `perip_req_i`=1, address unmapped** (`addr[31:28]` ≥ NSLV):
  - Load `perip_rdata_o` with `ERR_RDATA`, pulse `err_o` for one cycle.
  - Go to DONE without touching slave outputs.
- **ACCESS:**
  - If `s_ready_i[sel]`=1: capture `s_rdata_i[sel]` into `perip_rdata_o` on loads (unchanged on stores), drop `s_valid_o` and `s_sel_o`, go to DONE.
  - Otherwise increment the counter.
- **DONE:** unconditionally go to IDLE.
- `rib_hold_flag_o`:
  - IDLE: equals `perip_req_i` (combinational).
  - ACCESS: 1.
  - DONE: 0.
- `perip_rdata_o` holds its value until the next capture.
- The core finishes the instruction in the DONE cycle. A `perip_req_i` seen in DONE is ignored; the next request is accepted in IDLE.
- `s_ready_i` bits of non-selected slaves and all `s_ready_i` outside ACCESS are ignored.
- Reset, including mid-transaction: asynchronously return to IDLE; the in-flight access is dropped with no response.

## Timing
- Reset values: every output 0 (`perip_rdata_o`, `s_*`, `err_o`, `rib_hold_flag_o`); state IDLE; counter 0.
- Request seen at cycle T: hold=1 at T; ACCESS with `s_valid_o`=1 at T+1.
  - Zero-wait slave (ready at T+1): DONE at T+2, hold=0, data valid.
  - Minimum latency is 2 stall cycles (T, T+1).
- Each wait cycle on the slave adds one hold cycle.
- Unmapped access: hold at T, DONE at T+1, `err_o`=1 at T+1.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`; no wrap, because the timeout fires first.

## Configuration
- Macro: `PERIP_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - In ACCESS, when the counter reaches `TIMEOUT_CYCLES`-1 with no ready, the next edge aborts: drop `s_valid_o`/`s_sel_o`, load `ERR_RDATA` (loads only), pulse `err_o`, go to DONE.
  - Ready in the expiry cycle wins over timeout.
- **Undefined:** no counter logic; ACCESS waits indefinitely; `err_o` fires only for unmapped accesses.

## Structure
- Package `perip_bridge_pkg`:
  - state enum `pb_state_e` (IDLE, ACCESS, DONE);
  - `PB_IDX_MSB`=31 and `PB_IDX_LSB`=28;
  - default `ERR_RDATA`.
- Sub-module `perip_addr_decode` (combinational): takes the address and NSLV; outputs a one-hot select and an `unmapped` flag.

## Test plan
- Zero-wait load, addr 0x1000_0004, slave 1 rdata 0xCAFE_F00D: hold high 2 cycles, `perip_rdata_o`=0xCAFE_F00D in DONE, `s_sel_o`=4'b0010.
- Store to 0x2000_0010, wdata 0x1234_5678, slave 2 ready after 3 waits:
  - `s_we_o`=1, `s_wdata_o`=0x1234_5678;
  - hold high 5 cycles;
  - `perip_rdata_o` unchanged.
- Unmapped load, addr 0xF000_0000 with NSLV=4: no `s_valid_o`; hold 1 cycle; `err_o` pulse at T+1; rdata=`ERR_RDATA`.
- Timeout with macro defined, `TIMEOUT_CYCLES`=8, slave never ready:
  - `s_valid_o` high exactly 8 cycles;
  - then `err_o` pulse; DONE, hold=0.
- `rst_n` asserted in ACCESS (slave waiting): all outputs 0 immediately. After release, a fresh load completes normally.
- Back-to-back loads, requests held continuously: the second request is accepted only in the cycle after DONE. Each returns its own slave's data.
